// File: rtl/sec_ded_pkg.sv
// Shared SEC-DED definitions: word widths and the Hsiao H-matrix columns.
// The decoder imports this same package so encode and syndrome always agree.
package sec_ded_pkg;

  localparam int DATA_W = 32;
  localparam int CHK_W  = 7;
  localparam int CW_W   = DATA_W + CHK_W;

  // One distinct weight-3 column per data bit. Odd column weight lets the
  // decoder tell single errors (odd syndrome) from double errors (even).
  localparam logic [CHK_W-1:0] H_COL [0:DATA_W-1] = '{
    7'b0000111, 7'b0001011, 7'b0010011, 7'b0100011,
    7'b0001101, 7'b0001110, 7'b0010101, 7'b0010110,
    7'b0011001, 7'b0011010, 7'b0011100, 7'b0100101,
    7'b0100110, 7'b0101001, 7'b0101010, 7'b0101100,
    7'b0110001, 7'b0110010, 7'b0110100, 7'b0111000,
    7'b1000011, 7'b1000101, 7'b1000110, 7'b1001001,
    7'b1001010, 7'b1001100, 7'b1010001, 7'b1010010,
    7'b1010100, 7'b1011000, 7'b1100001, 7'b1100010
  };

endpackage

// File: rtl/sec_ded_chk_gen.sv
// Combinational check-bit generator: XOR of the H columns of every set data
// bit. The decoder reuses this block on received data to form its syndrome.
import sec_ded_pkg::*;

module sec_ded_chk_gen (
  input  logic [DATA_W-1:0] data,
  input  logic              unused_tie,
  output logic [CHK_W-1:0]  chk
);

  // Fold the selected H columns into the check word.
  always_comb begin
    chk = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (data[i]) chk = chk ^ H_COL[i];
    end
    chk = chk | {CHK_W{unused_tie & 1'b0}};
  end

endmodule

// File: rtl/sec_ded_enc_pipe.sv
// Two-stage SEC-DED encoder pipeline with valid/ready handshake, optional
// error injection and a wrapping delivered-word counter.
// S1 captures {data, inj}; S2 holds the finished codeword that drives OUT.
import sec_ded_pkg::*;

module sec_ded_enc_pipe #(
  parameter int DATA_W = 32,
  parameter int CHK_W  = 7
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_W-1:0]        IN,
  input  logic                     IN_VLD,
  output logic                     IN_RDY,
  input  logic [DATA_W+CHK_W-1:0]  INJ,
  output logic [DATA_W+CHK_W-1:0]  OUT,
  output logic                     OUT_VLD,
  input  logic                     OUT_RDY,
  output logic [15:0]              CNT
);

  localparam int CW = DATA_W + CHK_W;

  logic              s1_vld;
  logic [DATA_W-1:0] s1_data;
  logic [CW-1:0]     s1_inj;
  logic              s2_vld;
  logic [CW-1:0]     s2_cw;
  logic [CHK_W-1:0]  s1_chk;
  logic              s1_adv;
  logic              s2_adv;

  sec_ded_chk_gen u_chk_gen (
    .data       (s1_data),
    .unused_tie (1'b0),
    .chk        (s1_chk)
  );

  // Stage advance: a stage moves when empty or when its successor moves.
  // IN_RDY depends only on state, OUT_RDY and RST, never on IN_VLD.
  always_comb begin
    s2_adv = !s2_vld || OUT_RDY;
    s1_adv = !s1_vld || s2_adv;
    IN_RDY = !RST && s1_adv;
  end

  // Pipeline registers, injection XOR into S2 and delivery counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_vld  <= 1'b0;
      s1_data <= '0;
      s1_inj  <= '0;
      s2_vld  <= 1'b0;
      s2_cw   <= '0;
      CNT     <= '0;
    end else begin
      if (s1_adv) begin
        s1_vld <= IN_VLD;
        if (IN_VLD) begin
          s1_data <= IN;
          s1_inj  <= INJ;
        end
      end
      if (s2_adv) begin
        s2_vld <= s1_vld;
        if (s1_vld) s2_cw <= {s1_chk, s1_data} ^ s1_inj;
      end
      if (s2_vld && OUT_RDY) CNT <= CNT + 16'd1;
    end
  end

  assign OUT     = s2_cw;
  assign OUT_VLD = s2_vld;

endmodule
